// File: rtl/srl_fifo_if.sv
// Producer/consumer handshake bundle for srl_fifo; the FIFO takes the slave modport.
interface srl_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Both sides use valid/ready: a word transfers on a rising CLK edge where valid and ready are
  // both high. Valid never waits on ready, and data is held stable while valid is high and ready is low.
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_VALID;
  logic              WR_READY;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              RD_READY;
  logic [LW-1:0]     LEVEL;

  modport master (
    output WR_DATA, WR_VALID, RD_READY,
    input  WR_READY, RD_DATA, RD_VALID, LEVEL
  );

  modport slave (
    input  WR_DATA, WR_VALID, RD_READY,
    output WR_READY, RD_DATA, RD_VALID, LEVEL
  );
endinterface

// File: rtl/srl_fifo.sv
// Shallow FIFO on per-bit addressable shift registers (one SRL32E per data bit).
// Define SRL_FIFO_OUTREG_EN to add an output register (capacity DEPTH+1, read latency 2).
module srl_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter bit INIT   = 1'b0
) (
  input logic       CLK,
  input logic       RST_N,
  srl_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic              push;
  logic              srl_pop;
  logic              wr_ready_q;
  logic [LW-1:0]     cnt;
  logic [LW-1:0]     cnt_next;
  logic [LW-1:0]     cnt_m1;
  logic [AW-1:0]     tap_addr;
  logic [DATA_W-1:0] tap_data;

  // Storage is not reset; the declaration value is the power-up content of every bit.
  logic [DEPTH-1:0]  srl [DATA_W] = '{default: {DEPTH{INIT}}};

  assign push = bus.WR_VALID & wr_ready_q;

  always_comb begin
    cnt_next = cnt;
    case ({push, srl_pop})
      2'b10:   cnt_next = cnt + LW'(1);
      2'b01:   cnt_next = cnt - LW'(1);
      default: cnt_next = cnt;
    endcase
  end

  // WR_READY is a flop of the next count, so it never sees RD_READY combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      wr_ready_q <= (cnt_next != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      for (int b = 0; b < DATA_W; b++) begin
        srl[b] <= {srl[b][DEPTH-2:0], bus.WR_DATA[b]};
      end
    end
  end

  // The oldest entry sits at tap cnt-1; a simultaneous push and pop keeps the address
  // while the shift moves the next-oldest entry under it.
  always_comb begin
    cnt_m1   = cnt - LW'(1);
    tap_addr = cnt_m1[AW-1:0];
    tap_data = '0;
    for (int b = 0; b < DATA_W; b++) begin
      tap_data[b] = srl[b][tap_addr];
    end
  end

  assign bus.WR_READY = wr_ready_q;

`ifdef SRL_FIFO_OUTREG_EN
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  // The head moves into the output register whenever that register is free or being drained.
  assign srl_pop = (cnt != '0) & (~out_valid | bus.RD_READY);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= srl_pop | (out_valid & ~bus.RD_READY);
    end
  end

  always_ff @(posedge CLK) begin
    if (srl_pop) begin
      out_data <= tap_data;
    end
  end

  assign bus.RD_DATA  = out_data;
  assign bus.RD_VALID = out_valid;
  assign bus.LEVEL    = cnt + LW'(out_valid);
`else
  assign srl_pop      = (cnt != '0) & bus.RD_READY;
  assign bus.RD_DATA  = tap_data;
  assign bus.RD_VALID = (cnt != '0);
  assign bus.LEVEL    = cnt;
`endif

endmodule
